// File: rtl/div64_seq.sv
// Sequential 64-bit restoring divider: one quotient bit per clock, signed or unsigned,
// start/done handshake, adder-style status flags plus divide-by-zero.
module div64_seq #(
  parameter bit SIGNED_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        SF,
  output logic        ZF,
  output logic        PF,
  output logic        CF,
  output logic        OF,
  output logic        DZ
);

  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic [5:0] flags_q, flags_d;

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic mode_q, mode_d, sgn_quo_q, sgn_quo_d, sgn_rem_q, sgn_rem_d;

  logic [DATA_W:0] shifted;
  logic signed [DATA_W:0] trial;
  logic [DATA_W-1:0] quo_fix, rem_fix;
  logic dz, ovf;

  // The core always follows the mode port; the default only documents the tie-off.
  logic signed_default_unused;
  assign signed_default_unused = SIGNED_DEFAULT;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    flags_d   = flags_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;

    shifted = {rem_q, dvd_q[DATA_W-1]};
    trial   = $signed(shifted) - $signed({1'b0, dvs_q});
    dz      = (b_q == '0);
    ovf     = mode_q && (a_q == MIN_NEG) && (b_q == '1);
    quo_fix = dz ? '1  : cond_neg(dvd_q, sgn_quo_q);
    rem_fix = dz ? a_q : cond_neg(rem_q, sgn_rem_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          mode_d  = mode;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (dz) begin
          state_d = S_FIX;
        end else begin
          dvd_d     = cond_neg(a_q, mode_q && a_q[DATA_W-1]);
          dvs_d     = cond_neg(b_q, mode_q && b_q[DATA_W-1]);
          rem_d     = '0;
          sgn_quo_d = mode_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
          sgn_rem_d = mode_q && a_q[DATA_W-1];
          cnt_d     = 7'd63;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        // A negative trial difference means restore: keep the shifted remainder.
        dvd_d = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
        rem_d = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        if (cnt_q == 7'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 7'd1;
      end
      S_FIX: begin
        quo_d   = quo_fix;
        rmd_d   = rem_fix;
        flags_d = {quo_fix[DATA_W-1], (quo_fix == '0), ~^quo_fix[7:0],
                   (!dz && (rem_fix != '0)), ovf, dz};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      flags_q <= flags_d;
    end
  end

  // Working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q       <= a_d;
    b_q       <= b_d;
    mode_q    <= mode_d;
    rem_q     <= rem_d;
    dvd_q     <= dvd_d;
    dvs_q     <= dvs_d;
    sgn_quo_q <= sgn_quo_d;
    sgn_rem_q <= sgn_rem_d;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign {SF, ZF, PF, CF, OF, DZ} = flags_q;

endmodule

// File: tb/tb_div64_seq.sv
// Bench for div64_seq: directed vector table, handshake/reset sequences and
// randomized operations against a plain-arithmetic reference model.
module tb_div64_seq;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [63:0] A, B;
  logic        busy, done;
  logic [63:0] quotient, remainder;
  logic        SF, ZF, PF, CF, OF, DZ;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  div64_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A), .B(B),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .SF(SF), .ZF(ZF), .PF(PF), .CF(CF), .OF(OF), .DZ(DZ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        m;
    logic [63:0] q;
    logic [63:0] r;
    logic [5:0]  f;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] cur_flags();
    return {SF, ZF, PF, CF, OF, DZ};
  endfunction

  // Reference model: Verilog division semantics on the dividend/divisor values.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic m,
                       output logic [63:0] q, output logic [63:0] r,
                       output logic [5:0] f, output int lat);
    logic dz, of;
    longint sa, sb;
    dz = 1'b0; of = 1'b0; lat = 66;
    if (b == 64'd0) begin
      q = ONES; r = a; dz = 1'b1; lat = 2;
    end else if (m && a == MINV && b == ONES) begin
      q = MINV; r = 64'd0; of = 1'b1;
    end else if (m) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    f = {q[63], q == 64'd0, ~^q[7:0], !dz && r != 64'd0, of, dz};
  endtask

  task automatic wait_done(input int budget, inout bit bad_busy, output int lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && busy !== 1'b1) bad_busy = 1'b1;
      if (done === 1'b1 && busy !== 1'b0) bad_busy = 1'b1;
    end
    lat = cyc - acc_cyc;
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic m,
                        output logic [63:0] q, output logic [63:0] r,
                        output logic [5:0] f, output int lat);
    bit bad_busy;
    @(negedge clk);
    A = a; B = b; mode = m; start = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    A = ~a; B = b ^ 64'h1234; mode = ~m;
    bad_busy = (busy !== 1'b1);
    wait_done(200, bad_busy, lat);
    q = quotient; r = remainder; f = cur_flags();
    chk("busy_handshake", {63'd0, bad_busy}, 64'd0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [63:0] q, r, eq, er, ra, rb;
    logic [5:0] f, ef;
    int lat, elat;
    bit bad;
    logic rm;

    rst = 1'b1; start = 1'b0; mode = 1'b0; A = '0; B = '0;

    vecs.push_back('{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 6'b000100, 66});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 6'b100100, 66});
    vecs.push_back('{64'd5, 64'd0, 1'b0, ONES, 64'd5, 6'b101001, 2});
    vecs.push_back('{64'd5, 64'd0, 1'b1, ONES, 64'd5, 6'b101001, 2});
    vecs.push_back('{MINV, ONES, 1'b1, MINV, 64'd0, 6'b101010, 66});
    vecs.push_back('{64'd3, 64'd5, 1'b0, 64'd0, 64'd3, 6'b011100, 66});
    vecs.push_back('{ONES, 64'd3, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 6'b001000, 66});
    vecs.push_back('{MINV, ONES, 1'b0, 64'd0, MINV, 6'b011100, 66});
    vecs.push_back('{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 6'b100100, 66});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, ONES, 64'hFFFF_FFFF_FFFF_FFF8, 6'b101001, 2});
    vecs.push_back('{ONES, 64'd1, 1'b0, ONES, 64'd0, 6'b101000, 66});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 6'b000100, 66});
    vecs.push_back('{64'd0, 64'd5, 1'b1, 64'd0, 64'd0, 6'b011000, 66});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);
    chk("rst_flags", {58'd0, cur_flags()}, 64'd0);
    @(negedge clk) rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, q, r, f, lat);
      chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d_flags", i), {58'd0, f}, {58'd0, vecs[i].f});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    A = 64'd3; B = 64'd5; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    A = 64'd100; B = 64'd7; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 1'b0;
    wait_done(200, bad, lat);
    chk("ign_latency", 64'(lat), 64'd66);
    chk("ign_quotient", quotient, 64'd0);
    chk("ign_remainder", remainder, 64'd3);
    chk("ign_flags", {58'd0, cur_flags()}, {58'd0, 6'b011100});
    A = 64'd100; B = 64'd7; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc; start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_done_low", {63'd0, done}, 64'd0);
    chk("b2b_held_quotient", quotient, 64'd0);
    chk("b2b_held_remainder", remainder, 64'd3);
    bad = 1'b0;
    wait_done(200, bad, lat);
    chk("b2b_busy_handshake", {63'd0, bad}, 64'd0);
    chk("b2b_latency", 64'(lat), 64'd66);
    chk("b2b_quotient", quotient, 64'd14);
    chk("b2b_remainder", remainder, 64'd2);

    // Reset mid-operation aborts
    @(negedge clk);
    A = ONES; B = 64'd3; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_quotient", quotient, 64'd0);
    chk("abort_remainder", remainder, 64'd0);
    chk("abort_flags", {58'd0, cur_flags()}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bad = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("abort_quiet", {63'd0, bad}, 64'd0);
    run_op(ONES, 64'd3, 1'b0, q, r, f, lat);
    chk("rerun_quotient", q, 64'h5555_5555_5555_5555);
    chk("rerun_remainder", r, 64'd0);
    chk("rerun_flags", {58'd0, f}, {58'd0, 6'b001000});
    chk("rerun_latency", 64'(lat), 64'd66);

    // Randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      ra = {$urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = 64'd0;
        1: rb = ONES;
        2: rb = 64'($urandom_range(1, 15));
        3: rb = {32'd0, $urandom};
        4: rb = {$urandom, 32'd0} | 64'd1;
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 9) == 0) ra = MINV;
      if ($urandom_range(0, 9) == 0) ra = {32'd0, $urandom};
      model(ra, rb, rm, eq, er, ef, elat);
      run_op(ra, rb, rm, q, r, f, lat);
      chk($sformatf("rnd%0d_quotient a=%h b=%h m=%0d", n, ra, rb, rm), q, eq);
      chk($sformatf("rnd%0d_remainder", n), r, er);
      chk($sformatf("rnd%0d_flags", n), {58'd0, f}, {58'd0, ef});
      chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div64_seq.md
# div64_seq

Multicycle 64-bit integer divider for the calculator's integer arithmetic unit, the inverse-operation counterpart to the 64-bit adder/subtractor. It computes quotient and remainder of `A / B`, signed or unsigned, using radix-2 restoring division at one quotient bit per clock. It uses a start/done handshake and reports status flags in the same style as the adder (SF, ZF, PF, CF, OF) plus a divide-by-zero flag.

## Interface
- `SIGNED_DEFAULT`, 0, value of `mode` semantics when tied off by the integrator; the core always obeys the `mode` port.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  1  0 = unsigned, 1 = signed two's complement; sampled with `start`.
- `A`  in  64  dividend; sampled with `start`.
- `B`  in  64  divisor; sampled with `start`.
- `busy`  out  1  high from the accepting edge until the result edge.
- `done`  out  1  one-cycle pulse; outputs are valid while high and held afterwards.
- `quotient`  out  64  result quotient.
- `remainder`  out  64  result remainder.
- `SF`  out  1  `quotient[63]`.
- `ZF`  out  1  quotient == 0.
- `PF`  out  1  even parity of `quotient[7:0]` (1 when the count of ones is even).
- `CF`  out  1  remainder != 0 (inexact division).
- `OF`  out  1  signed overflow: `mode`=1, A = 0x8000_0000_0000_0000, B = all ones.
- `DZ`  out  1  divide by zero (B == 0).

## Operation
- States: IDLE, PREP, CALC, FIX.
- IDLE: on `start`=1, latch A, B and mode, then go to PREP and set `busy`=1.
- PREP: if B == 0, go to FIX with the divide-by-zero result. Otherwise load |A| and |B| (absolute values only when mode=1), record sign_q = A[63]^B[63] and sign_r = A[63] (both 0 when unsigned), set the 7-bit counter to 63, and go to CALC.
- CALC: each cycle, shift {partial remainder, dividend} left by 1 and trial-subtract the divisor using a 65-bit subtract. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0. After the iteration with counter = 0, go to FIX; otherwise decrement the counter.
- FIX: negate the quotient if sign_q=1 and the remainder if sign_r=1. Register quotient, remainder and all flags, pulse `done`, clear `busy`, and return to IDLE.
- Signed semantics: the quotient truncates toward zero and the remainder takes the dividend's sign. Overflow case: quotient = 0x8000_0000_0000_0000, remainder = 0, OF=1.
- Divide by zero: quotient = all ones, remainder = A, DZ=1, CF=0. ZF, SF and PF are computed from that quotient.
- `start` outside IDLE is ignored (no queueing). Input changes after acceptance have no effect.
- Outputs and flags hold their last result until the next FIX.

## Timing
- Reset: state IDLE; `busy`, `done`, `quotient`, `remainder` and all flags are 0. Reset asserted mid-operation aborts immediately: no `done`, and outputs are 0.
- Edge 0 is the edge that accepts `start`. Edge 1 is PREP to CALC. Edges 2–65 are the 64 CALC iterations. At edge 66 FIX registers the results: `done`=1 and `busy`=0 for the following cycle.
- Latency is 66 cycles from the accepting edge to `done` high, for every non-zero divisor.
- Divide by zero: PREP goes to FIX at edge 1, and `done` is high after edge 2 (latency 2).
- Back-to-back operation: state is IDLE while `done` is high, so `start` in the `done` cycle is accepted. The previous outputs remain until that operation's FIX.
- `busy` and `done` are never high together.

## Test plan
- Unsigned 100 / 7 -> `done` high 66 cycles after the accepting edge; quotient=14, remainder=2, CF=1, ZF=0, SF=0, OF=0, DZ=0.
- Signed −7 / 2 (A=0xFFFF_FFFF_FFFF_FFF9) -> quotient=0xFFFF_FFFF_FFFF_FFFD (−3), remainder=0xFFFF_FFFF_FFFF_FFFF (−1), SF=1, CF=1.
- A=5, B=0 (either mode) -> `done` after 2 cycles; DZ=1, quotient=all ones, remainder=5, PF=1, ZF=0.
- Signed 0x8000_0000_0000_0000 / all ones -> quotient=0x8000_0000_0000_0000, remainder=0, OF=1, SF=1, CF=0, latency 66.
- Unsigned 3 / 5 -> quotient=0, remainder=3, ZF=1, PF=1, CF=1. A second `start` pulsed at cycle 10 is ignored; a `start` in the `done` cycle is accepted, and `busy`=1 on the next cycle.
- Start unsigned 0xFFFF_FFFF_FFFF_FFFF / 3 and assert `rst` at cycle 30 -> `busy`=0, outputs 0, no `done`. After release, rerun to completion -> quotient=0x5555_5555_5555_5555, remainder=0, PF=1.
